// File: rtl/seq_det_pkg.sv
// Shared state encodings and the target pattern for the time-shared "1011" detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } sched_state_e;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } det_state_e;

  localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/seq_moore_core.sv
// Moore detector for the serial pattern 1011 with overlap; clear wins over the data input.
module seq_moore_core
  import seq_det_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic sequence_in,
  output logic detector_out
);

  det_state_e r_state;
  det_state_e w_state_next;

  // State register with synchronous reset and synchronous clear
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S0;
    end else if (clear) begin
      r_state <= S0;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Transition function; S4 re-enters the pattern on overlap
  always_comb begin
    w_state_next = S0;
    case (r_state)
      S0:      w_state_next = (sequence_in == PATTERN[3]) ? S1 : S0;
      S1:      w_state_next = (sequence_in == PATTERN[2]) ? S2 : S1;
      S2:      w_state_next = (sequence_in == PATTERN[1]) ? S3 : S0;
      S3:      w_state_next = (sequence_in == PATTERN[0]) ? S4 : S2;
      S4:      w_state_next = sequence_in ? S1 : S2;
      default: w_state_next = S0;
    endcase
  end

  assign detector_out = (r_state == S4);

endmodule

// File: rtl/seq_detect_scheduler.sv
// Round-robin front end that feeds one requester word at a time, MSB first, through the
// shared 1011 detector and reports the match count tagged with the requester id.
module seq_detect_scheduler
  import seq_det_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = $clog2(DATA_W + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      sequence_out,
  output logic                      detector_out,
  output logic                      done,
  output logic [ID_W-1:0]           done_id,
  output logic [CNT_W-1:0]          match_count
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [ID_W:0]    REQ_N    = (ID_W + 1)'(NUM_REQ);

  sched_state_e        r_state;
  sched_state_e        w_state_next;
  logic [DATA_W-1:0]   r_shreg;
  logic [ID_W-1:0]     r_id;
  logic [ID_W-1:0]     r_last_id;
  logic [CNT_W-1:0]    r_bit_idx;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    r_match_count;
  logic [ID_W-1:0]     r_done_id;
  logic [NUM_REQ-1:0]  r_grant;

  logic [DATA_W-1:0]   w_words [NUM_REQ];
  logic [ID_W:0]       w_cand;
  logic [ID_W-1:0]     w_winner;
  logic                w_any_req;
  logic                w_start;
  logic [NUM_REQ-1:0]  w_grant_vec;
  logic                w_det_out;

  // Unpack the flat request bus into per-requester words
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_words[i] = data_in[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin search starting just after the last granted requester
  always_comb begin
    w_any_req = 1'b0;
    w_winner  = {ID_W{1'b0}};
    w_cand    = {(ID_W + 1){1'b0}};
    for (int off = 0; off < NUM_REQ; off++) begin
      w_cand    = {1'b0, r_last_id} + (ID_W + 1)'(off + 1);
      w_cand    = (w_cand >= REQ_N) ? (w_cand - REQ_N) : w_cand;
      w_winner  = (!w_any_req && req[w_cand[ID_W-1:0]]) ? w_cand[ID_W-1:0] : w_winner;
      w_any_req = w_any_req | req[w_cand[ID_W-1:0]];
    end
  end

  assign w_grant_vec = {{(NUM_REQ - 1){1'b0}}, 1'b1} << w_winner;

  // Scheduler state register
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Scheduler next-state logic; a job starts only from IDLE
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_next = SHIFT;
          w_start      = 1'b1;
        end else begin
          w_state_next = IDLE;
        end
      end
      SHIFT: begin
        if (r_bit_idx == LAST_BIT) begin
          w_state_next = DRAIN;
        end else begin
          w_state_next = SHIFT;
        end
      end
      DRAIN:   w_state_next = REPORT;
      REPORT:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Job datapath: capture, shift, count, and publish the result in DRAIN
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_shreg       <= {DATA_W{1'b0}};
      r_id          <= {ID_W{1'b0}};
      r_last_id     <= ID_W'(NUM_REQ - 1);
      r_bit_idx     <= {CNT_W{1'b0}};
      r_count       <= {CNT_W{1'b0}};
      r_match_count <= {CNT_W{1'b0}};
      r_done_id     <= {ID_W{1'b0}};
      r_grant       <= {NUM_REQ{1'b0}};
    end else begin
      r_grant <= w_start ? w_grant_vec : {NUM_REQ{1'b0}};
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_shreg   <= w_words[w_winner];
            r_id      <= w_winner;
            r_last_id <= w_winner;
            r_bit_idx <= {CNT_W{1'b0}};
            r_count   <= {CNT_W{1'b0}};
          end
        end
        SHIFT: begin
          r_shreg   <= {r_shreg[DATA_W-2:0], 1'b0};
          r_bit_idx <= r_bit_idx + CNT_W'(1);
          if (w_det_out) begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        DRAIN: begin
          // The last bit's Moore output only becomes visible here
          r_match_count <= r_count + CNT_W'(w_det_out);
          r_done_id     <= r_id;
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

  seq_moore_core u_core (
    .clock        (clock),
    .reset        (reset),
    .clear        (w_start),
    .sequence_in  (sequence_out),
    .detector_out (w_det_out)
  );

  assign sequence_out = (r_state == SHIFT) & r_shreg[DATA_W-1];
  assign detector_out = w_det_out;
  assign busy         = (r_state != IDLE);
  assign done         = (r_state == REPORT);
  assign grant        = r_grant;
  assign done_id      = r_done_id;
  assign match_count  = r_match_count;

endmodule
